// File: rtl/ccu_snoop_sequencer.sv
// Snoop sequencer: fans one ACE snoop out to every non-initiating master,
// gathers and OR-merges the CR responses, then forwards CD data from the
// lowest-index supplier while draining data from every other supplier.
module ccu_snoop_sequencer #(
  parameter int unsigned NoPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  // Derived; leave at default.
  parameter int unsigned IdxW      = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // Request side (CCU FSM)
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [3:0]                   req_snoop_i,
  input  logic [2:0]                   req_prot_i,
  input  logic [IdxW-1:0]              req_initiator_i,
  // AC channels
  output logic [NoPorts-1:0]           ac_valid_o,
  input  logic [NoPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]         ac_addr_o,
  output logic [3:0]                   ac_snoop_o,
  output logic [2:0]                   ac_prot_o,
  // CR channels
  input  logic [NoPorts-1:0]           cr_valid_i,
  output logic [NoPorts-1:0]           cr_ready_o,
  input  logic [5*NoPorts-1:0]         cr_resp_i,
  // CD channels
  input  logic [NoPorts-1:0]           cd_valid_i,
  output logic [NoPorts-1:0]           cd_ready_o,
  input  logic [DataWidth*NoPorts-1:0] cd_data_i,
  input  logic [NoPorts-1:0]           cd_last_i,
  // Merged result
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [4:0]                   res_resp_o,
  output logic                         res_data_avail_o,
  output logic [IdxW-1:0]              res_data_port_o,
  // Forwarded data
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [DataWidth-1:0]         data_o,
  output logic                         data_last_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNOOP = 2'd1,
    S_RESP  = 2'd2,
    S_DATA  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NoPorts-1:0]     ac_pend_q, ac_pend_d;   // targets still owing an AC handshake
  logic [NoPorts-1:0]     cr_pend_q, cr_pend_d;   // targets still owing a CR response
  logic [NoPorts-1:0]     dtx_q, dtx_d;           // ports that will (still) send CD data
  logic [4:0]             acc_q, acc_d;           // OR of collected CRRESP
  logic [IdxW-1:0]        sup_q, sup_d;           // latched supplier for the DATA phase
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [2:0]             prot_q, prot_d;

  // Lowest set index of a port mask (0 when empty).
  function automatic logic [IdxW-1:0] lowest_idx(input logic [NoPorts-1:0] m);
    lowest_idx = '0;
    for (int i = int'(NoPorts) - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IdxW'(i);
    end
  endfunction

  assign ac_addr_o  = addr_q;
  assign ac_snoop_o = snoop_q;
  assign ac_prot_o  = prot_q;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d          = state_q;
    ac_pend_d        = ac_pend_q;
    cr_pend_d        = cr_pend_q;
    dtx_d            = dtx_q;
    acc_d            = acc_q;
    sup_d            = sup_q;
    addr_d           = addr_q;
    snoop_d          = snoop_q;
    prot_d           = prot_q;
    req_ready_o      = 1'b0;
    ac_valid_o       = '0;
    cr_ready_o       = '0;
    cd_ready_o       = '0;
    res_valid_o      = 1'b0;
    res_resp_o       = '0;
    res_data_avail_o = 1'b0;
    res_data_port_o  = '0;
    data_valid_o     = 1'b0;
    data_o           = '0;
    data_last_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          snoop_d = req_snoop_i;
          prot_d  = req_prot_i;
          acc_d   = '0;
          dtx_d   = '0;
          // An out-of-range initiator matches no port, so all are targeted.
          for (int i = 0; i < int'(NoPorts); i++) begin
            ac_pend_d[i] = (32'(req_initiator_i) != 32'(i));
          end
          cr_pend_d = ac_pend_d;
          state_d   = (ac_pend_d == '0) ? S_RESP : S_SNOOP;
        end
      end

      S_SNOOP: begin
        ac_valid_o = ac_pend_q;
        // CR is only accepted once that port's AC is done; this also keeps
        // AC and CR of one port out of the same cycle.
        cr_ready_o = cr_pend_q & ~ac_pend_q;
        ac_pend_d  = ac_pend_q & ~ac_ready_i;
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (cr_ready_o[i] && cr_valid_i[i]) begin
            cr_pend_d[i] = 1'b0;
            acc_d        = acc_d | cr_resp_i[5*i +: 5];
            if (cr_resp_i[5*i]) dtx_d[i] = 1'b1;
          end
        end
        if (cr_pend_d == '0) state_d = S_RESP;
      end

      S_RESP: begin
        res_valid_o      = 1'b1;
        res_resp_o       = acc_q;
        res_data_avail_o = |dtx_q;
        res_data_port_o  = lowest_idx(dtx_q);
        if (res_ready_i) begin
          sup_d   = lowest_idx(dtx_q);
          state_d = (dtx_q != '0) ? S_DATA : S_IDLE;
        end
      end

      S_DATA: begin
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (dtx_q[i]) begin
            if (IdxW'(i) == sup_q) begin
              cd_ready_o[i] = data_ready_i;
              data_valid_o  = cd_valid_i[i];
              data_o        = cd_data_i[DataWidth*i +: DataWidth];
              data_last_o   = cd_last_i[i];
            end else begin
              cd_ready_o[i] = 1'b1;
            end
          end
        end
        dtx_d = dtx_q & ~(cd_ready_o & cd_valid_i & cd_last_i);
        if (dtx_d == '0) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      dtx_q     <= '0;
      acc_q     <= '0;
      sup_q     <= '0;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
    end else begin
      state_q   <= state_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      dtx_q     <= dtx_d;
      acc_q     <= acc_d;
      sup_q     <= sup_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_sequencer.sv
// Directed bench for ccu_snoop_sequencer: a 4-port instance for the main
// flows and a 1-port instance for the no-target corner.
module tb_ccu_snoop_sequencer;

  logic clk;
  logic rst_n;

  // 4-port instance
  logic         req_valid, req_ready;
  logic [63:0]  req_addr;
  logic [3:0]   req_snoop;
  logic [2:0]   req_prot;
  logic [1:0]   req_init;
  logic [3:0]   ac_valid, ac_ready;
  logic [63:0]  ac_addr;
  logic [3:0]   ac_snoop;
  logic [2:0]   ac_prot;
  logic [3:0]   cr_valid, cr_ready;
  logic [19:0]  cr_resp;
  logic [3:0]   cd_valid, cd_ready, cd_last;
  logic [255:0] cd_data;
  logic         res_valid, res_ready, res_avail;
  logic [4:0]   res_resp;
  logic [1:0]   res_port;
  logic         data_valid, data_ready, data_last;
  logic [63:0]  data;

  // 1-port instance
  logic         b_req_valid, b_req_ready;
  logic [0:0]   b_req_init;
  logic [0:0]   b_ac_valid, b_ac_ready;
  logic [63:0]  b_ac_addr;
  logic [3:0]   b_ac_snoop;
  logic [2:0]   b_ac_prot;
  logic [0:0]   b_cr_valid, b_cr_ready;
  logic [4:0]   b_cr_resp;
  logic [0:0]   b_cd_valid, b_cd_ready, b_cd_last;
  logic [63:0]  b_cd_data;
  logic         b_res_valid, b_res_ready, b_res_avail;
  logic [4:0]   b_res_resp;
  logic [0:0]   b_res_port;
  logic         b_data_valid, b_data_ready, b_data_last;
  logic [63:0]  b_data;

  int n_vec = 0;
  int n_err = 0;

  ccu_snoop_sequencer #(.NoPorts(4), .AddrWidth(64), .DataWidth(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_snoop_i(req_snoop), .req_prot_i(req_prot), .req_initiator_i(req_init),
    .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr),
    .ac_snoop_o(ac_snoop), .ac_prot_o(ac_prot),
    .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
    .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_resp_o(res_resp),
    .res_data_avail_o(res_avail), .res_data_port_o(res_port),
    .data_valid_o(data_valid), .data_ready_i(data_ready), .data_o(data), .data_last_o(data_last)
  );

  ccu_snoop_sequencer #(.NoPorts(1), .AddrWidth(64), .DataWidth(64)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(req_addr),
    .req_snoop_i(req_snoop), .req_prot_i(req_prot), .req_initiator_i(b_req_init),
    .ac_valid_o(b_ac_valid), .ac_ready_i(b_ac_ready), .ac_addr_o(b_ac_addr),
    .ac_snoop_o(b_ac_snoop), .ac_prot_o(b_ac_prot),
    .cr_valid_i(b_cr_valid), .cr_ready_o(b_cr_ready), .cr_resp_i(b_cr_resp),
    .cd_valid_i(b_cd_valid), .cd_ready_o(b_cd_ready), .cd_data_i(b_cd_data), .cd_last_i(b_cd_last),
    .res_valid_o(b_res_valid), .res_ready_i(b_res_ready), .res_resp_o(b_res_resp),
    .res_data_avail_o(b_res_avail), .res_data_port_o(b_res_port),
    .data_valid_o(b_data_valid), .data_ready_i(b_data_ready), .data_o(b_data), .data_last_o(b_data_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one request on the 4-port instance; returns in the first SNOOP cycle.
  task automatic issue(input logic [1:0] init);
    req_init  = init;
    req_valid = 1'b1;
    #1 chk("req_ready_idle", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  // Initiator 0, ports 1..3 ready, all responses zero: no data phase.
  task automatic t_basic(input string tg);
    ac_ready = 4'b1110; cr_valid = 4'b1110; cr_resp = '0; res_ready = 1'b0;
    req_addr = 64'h1234_5678_9abc_def0; req_snoop = 4'h1; req_prot = 3'h2;
    issue(2'd0);
    chk({tg, "_ac_valid"}, 64'(ac_valid), 64'hE);
    chk({tg, "_ac_addr"}, ac_addr, 64'h1234_5678_9abc_def0);
    chk({tg, "_ac_snoop"}, 64'(ac_snoop), 64'h1);
    chk({tg, "_ac_prot"}, 64'(ac_prot), 64'h2);
    chk({tg, "_cr_ready_c1"}, 64'(cr_ready), 64'h0);
    tick();
    chk({tg, "_ac_valid_c2"}, 64'(ac_valid), 64'h0);
    chk({tg, "_cr_ready_c2"}, 64'(cr_ready), 64'hE);
    chk({tg, "_res_valid_c2"}, 64'(res_valid), 64'h0);
    tick();
    chk({tg, "_res_valid_c3"}, 64'(res_valid), 64'h1);
    chk({tg, "_res_resp"}, 64'(res_resp), 64'h0);
    chk({tg, "_res_avail"}, 64'(res_avail), 64'h0);
    tick();
    chk({tg, "_res_hold"}, 64'(res_valid), 64'h1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; cr_valid = '0;
    #1;
    chk({tg, "_idle_ready"}, 64'(req_ready), 64'h1);
    chk({tg, "_idle_res"}, 64'(res_valid), 64'h0);
    chk({tg, "_idle_cd"}, 64'(cd_ready), 64'h0);
  endtask

  // Port 1 supplies one last beat; enter DATA with data_ready low.
  task automatic t_to_data();
    ac_ready = 4'b1111; cr_valid = 4'b1110; res_ready = 1'b0; data_ready = 1'b0;
    cr_resp = {5'b00000, 5'b00000, 5'b00001, 5'b00000};
    issue(2'd0);
    tick(); tick();
    chk("sup1_res_valid", 64'(res_valid), 64'h1);
    chk("sup1_res_resp", 64'(res_resp), 64'h01);
    chk("sup1_port", 64'(res_port), 64'h1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; cr_valid = '0;
    cd_data = '0; cd_data[64 +: 64] = 64'hC1C1;
    cd_valid = 4'b0010; cd_last = 4'b0010;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_addr = '0; req_snoop = '0; req_prot = '0; req_init = '0;
    ac_ready = '0; cr_valid = '0; cr_resp = '0; cd_valid = '0; cd_data = '0; cd_last = '0;
    res_ready = 0; data_ready = 0;
    b_req_valid = 0; b_req_init = '0; b_ac_ready = '0; b_cr_valid = '0; b_cr_resp = '0;
    b_cd_valid = '0; b_cd_data = '0; b_cd_last = '0; b_res_ready = 0; b_data_ready = 0;

    #12;
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_ac_valid", 64'(ac_valid), 64'h0);
    chk("rst_cr_ready", 64'(cr_ready), 64'h0);
    chk("rst_cd_ready", 64'(cd_ready), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_resp", 64'(res_resp), 64'h0);
    chk("rst_data_valid", 64'(data_valid), 64'h0);
    chk("rst_ac_addr", ac_addr, 64'h0);
    chk("rst_b_req_ready", 64'(b_req_ready), 64'h1);
    #1 rst_n = 1'b1;

    // Basic three-target snoop with no data.
    t_basic("basic");

    // Two suppliers: port 2 forwarded, port 3 drained.
    ac_ready = 4'b1111; cr_valid = 4'b1101;
    cr_resp = {5'b01001, 5'b00101, 5'b00000, 5'b00000};
    issue(2'd1);
    chk("two_ac_valid", 64'(ac_valid), 64'hD);
    tick();
    chk("two_cr_ready", 64'(cr_ready), 64'hD);
    tick();
    chk("two_res_valid", 64'(res_valid), 64'h1);
    chk("two_res_resp", 64'(res_resp), 64'h0D);
    chk("two_res_avail", 64'(res_avail), 64'h1);
    chk("two_res_port", 64'(res_port), 64'h2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; cr_valid = '0; data_ready = 1'b1;
    cd_data = '0; cd_data[128 +: 64] = 64'hA1; cd_data[192 +: 64] = 64'hB1;
    cd_valid = 4'b1100; cd_last = 4'b0000;
    #1;
    chk("two_b1_valid", 64'(data_valid), 64'h1);
    chk("two_b1_data", data, 64'hA1);
    chk("two_b1_last", 64'(data_last), 64'h0);
    chk("two_b1_cd_ready", 64'(cd_ready), 64'hC);
    tick();
    cd_data[128 +: 64] = 64'hA2; cd_data[192 +: 64] = 64'hB2; cd_last = 4'b1100;
    #1;
    chk("two_b2_data", data, 64'hA2);
    chk("two_b2_last", 64'(data_last), 64'h1);
    tick();
    cd_valid = '0; cd_last = '0; data_ready = 1'b0;
    #1;
    chk("two_idle", 64'(req_ready), 64'h1);
    chk("two_idle_dv", 64'(data_valid), 64'h0);

    // Staggered AC ready; early CR on port 1 must stall.
    ac_ready = 4'b0110; cr_valid = 4'b1110; cr_resp = '0;
    issue(2'd0);
    chk("stg_ac_c1", 64'(ac_valid), 64'hE);
    chk("stg_cr_early", 64'(cr_ready), 64'h0);
    tick();
    chk("stg_ac_c2", 64'(ac_valid), 64'h8);
    chk("stg_cr_c2", 64'(cr_ready), 64'h6);
    tick();
    chk("stg_cr_c3", 64'(cr_ready), 64'h0);
    chk("stg_res_c3", 64'(res_valid), 64'h0);
    tick();
    chk("stg_ac_c4", 64'(ac_valid), 64'h8);
    ac_ready = 4'b1110;
    tick();
    #1;
    chk("stg_ac_c5", 64'(ac_valid), 64'h0);
    chk("stg_cr_c5", 64'(cr_ready), 64'h8);
    chk("stg_res_c5", 64'(res_valid), 64'h0);
    tick();
    chk("stg_res", 64'(res_valid), 64'h1);
    chk("stg_avail", 64'(res_avail), 64'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; cr_valid = '0;
    #1 chk("stg_idle", 64'(req_ready), 64'h1);

    // Back-pressure on the forwarded data path.
    t_to_data();
    for (int k = 0; k < 4; k++) begin
      chk("bp_cd_ready", 64'(cd_ready), 64'h0);
      chk("bp_data_valid", 64'(data_valid), 64'h1);
      chk("bp_data", data, 64'hC1C1);
      tick();
    end
    data_ready = 1'b1;
    #1 chk("bp_release", 64'(cd_ready), 64'h2);
    tick();
    cd_valid = '0; cd_last = '0; data_ready = 1'b0;
    #1 chk("bp_idle", 64'(req_ready), 64'h1);

    // Single-port instance: no targets, straight to result.
    b_req_valid = 1'b1;
    #1 chk("one_req_ready", 64'(b_req_ready), 64'h1);
    tick();
    b_req_valid = 1'b0;
    #1;
    chk("one_res_valid", 64'(b_res_valid), 64'h1);
    chk("one_ac_valid", 64'(b_ac_valid), 64'h0);
    chk("one_res_resp", 64'(b_res_resp), 64'h0);
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    #1 chk("one_idle", 64'(b_req_ready), 64'h1);

    // Asynchronous reset in the middle of DATA.
    t_to_data();
    chk("rstd_in_data", 64'(data_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstd_req_ready", 64'(req_ready), 64'h1);
    chk("rstd_data_valid", 64'(data_valid), 64'h0);
    chk("rstd_cd_ready", 64'(cd_ready), 64'h0);
    chk("rstd_res_valid", 64'(res_valid), 64'h0);
    chk("rstd_ac_addr", ac_addr, 64'h0);
    cd_valid = '0; cd_last = '0;
    #1 rst_n = 1'b1;
    t_basic("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_sequencer.md
Name: ccu_snoop_sequencer

Overview:
- Sequences one snoop transaction at a time for the CCU FSM: broadcasts an AC request to every snooped master except the initiator.
- Collects every CR response, reports the OR-merged result, then forwards CD data from one supplier port and drains data from all other supplying ports.
- Sits between the CCU control FSM (request/result/data side) and the per-port snoop buses (AC/CR/CD).

Parameters:
- NoPorts, 2, number of snooped ACE masters (≥1).
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- IdxW, derived: max(1, $clog2(NoPorts)), port index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  snoop request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  AddrWidth  snoop address
- req_snoop_i  in  4  ACSNOOP code
- req_prot_i  in  3  ACPROT
- req_initiator_i  in  IdxW  port excluded from snooping
- ac_valid_o  out  NoPorts  per-port AC valid
- ac_ready_i  in  NoPorts  per-port AC ready
- ac_addr_o  out  AddrWidth  shared AC address (registered)
- ac_snoop_o  out  4  shared ACSNOOP
- ac_prot_o  out  3  shared ACPROT
- cr_valid_i  in  NoPorts  CR valid
- cr_ready_o  out  NoPorts  CR ready
- cr_resp_i  in  5*NoPorts  CRRESP per port: [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
- cd_valid_i  in  NoPorts  CD valid
- cd_ready_o  out  NoPorts  CD ready
- cd_data_i  in  DataWidth*NoPorts  CD data
- cd_last_i  in  NoPorts  CD last
- res_valid_o  out  1  merged result valid
- res_ready_i  in  1  result accepted
- res_resp_o  out  5  bitwise OR of all collected CRRESP
- res_data_avail_o  out  1  some port has DataTransfer=1
- res_data_port_o  out  IdxW  supplier: lowest index with DataTransfer=1
- data_valid_o  out  1  forwarded CD beat valid
- data_ready_i  in  1  forwarded beat accepted
- data_o  out  DataWidth  forwarded CD data
- data_last_o  out  1  forwarded CD last

Behaviour:
- Reset: state IDLE; all masks cleared; req_ready_o=1; ac_valid_o, cr_ready_o, cd_ready_o, res_valid_o, data_valid_o = 0; res_resp_o=0; res_data_avail_o=0; res_data_port_o=0; ac_* payload 0. Reset mid-transaction discards all state, with no completion.
- IDLE: req_ready_o=1. On handshake, register addr/snoop/prot and target mask = all ports except initiator (initiator ≥ NoPorts: all ports). Go to SNOOP, or to RESP if the target mask is empty.
- SNOOP: req_ready_o=0.
  - ac_valid_o[i]=1 for targets not yet AC-handshaken; a bit clears on ac_valid&ac_ready, per port and independent.
  - cr_ready_o[i]=1 only for ports whose AC has handshaken and whose CR is pending. CR arriving earlier is stalled.
  - On a CR handshake: OR resp into the accumulator; set the dtx mask bit if resp[0].
  - AC and CR of the same port may not handshake in the same cycle.
  - When all targets have CR done (same-cycle last CR counts), go to RESP next cycle.
- RESP: res_valid_o=1, outputs stable until res_ready_i. On handshake: go to DATA if the dtx mask is non-zero, else IDLE.
- DATA:
  - Supplier port p: cd_ready_o[p]=data_ready_i; data_valid_o=cd_valid_i[p]; data_o/data_last_o from port p (combinational pass-through).
  - Other dtx ports: cd_ready_o=1 (drain, discarded).
  - A port's dtx bit clears on its CD handshake with last=1.
  - Non-dtx ports: cd_ready_o=0.
  - When the mask empties, go to IDLE. The next request can be accepted on the following cycle.
- Minimum latency, request handshake to res_valid_o, with AC/CR ready immediately: 3 cycles (AC at +1, CR at +2, RESP at +3).
- Accumulator and masks cleared on entry to SNOOP.

Test Plan:
- NoPorts=4, initiator 0, ports 1-3 ready, all CRRESP=0 → AC on 1..3 only, res_valid_o at cycle 3, res_resp_o=0, data_avail=0, returns to IDLE with no DATA state.
- Initiator 1; port 2 resp=5'b00101, port 3 resp=5'b01001, 2-beat CD from each → res_resp_o=5'b01101, data_port=2; port 2 beats forwarded with last on beat 2; port 3 drained; IDLE after both lasts.
- ac_ready staggered (port 3 at +5 cycles); port 1 CR valid before its AC handshake → cr_ready_o[1]=0 until its AC handshakes; result only after port 3 CR.
- data_ready_i held low 4 cycles in DATA → cd_ready_o[supplier]=0, data_o stable, no beat lost.
- NoPorts=1, initiator 0 → no AC issued, res_valid_o next cycle with resp 0.
- rst_ni asserted mid-DATA → all outputs return to reset values asynchronously; the next request proceeds normally.
